// File: rtl/fewcore_ctrl_pkg.sv
// Shared types and constants for fewcore pipeline control logic.
package fewcore_ctrl_pkg;

  localparam int REG_W_DEF  = 5;
  // History rd field is sized for the widest register file we build; narrower REG_W zero-extends.
  localparam int HIST_RD_W  = 8;
  localparam int FWD_SEL_RF = 0;

  typedef struct packed {
    logic                 valid;
    logic                 we;
    logic [HIST_RD_W-1:0] rd;
    logic                 is_load;
  } hist_entry_t;

endpackage

// File: rtl/fwd_priority_sel.sv
// Match-and-priority encoder for one source operand over the in-flight write history.
module fwd_priority_sel
  import fewcore_ctrl_pkg::*;
#(
  parameter int REG_W     = REG_W_DEF,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 2,
  parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  hist_entry_t [FWD_DEPTH-1:0] hist,
  input  logic [REG_W-1:0]            rs,
  input  logic                        used,
  output logic [SEL_W-1:0]            sel,
  output logic                        load_hazard
);

  logic [FWD_DEPTH-1:0] match;

  always_comb begin
    for (int k = 0; k < FWD_DEPTH; k++) begin
      match[k] = used && hist[k].valid && hist[k].we &&
                 (hist[k].rd == HIST_RD_W'(rs)) && (rs != '0);
    end
  end

  // Lowest index is the youngest writer, so the first hit wins the select.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    sel         = SEL_W'(FWD_SEL_RF);
    load_hazard = 1'b0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (match[k]) sel = SEL_W'(k + 1);
      if (match[k] && hist[k].is_load && (k < LOAD_LAT - 1)) load_hazard = 1'b1;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Forwarding select and load-use stall control; load-use stalling is compiled in
// only when HAZARD_LOAD_USE_STALL_EN is defined.
module hazard_unit
  import fewcore_ctrl_pkg::*;
#(
  parameter int REG_W     = REG_W_DEF,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 2,
  parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       issue_valid,
  input  logic                       issue_we,
  input  logic [REG_W-1:0]           issue_rd,
  input  logic                       issue_is_load,
  input  logic [NUM_SRC*REG_W-1:0]   src_rs,
  input  logic [NUM_SRC-1:0]         src_used,
  input  logic                       flush,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
  output logic                       stall,
  output logic [15:0]                stall_count
);

  hist_entry_t [FWD_DEPTH-1:0] hist;
  hist_entry_t                 new_entry;
  logic [NUM_SRC-1:0]          hazard;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_priority_sel #(
      .REG_W    (REG_W),
      .FWD_DEPTH(FWD_DEPTH),
      .LOAD_LAT (LOAD_LAT),
      .SEL_W    (SEL_W)
    ) u_sel (
      .hist       (hist),
      .rs         (src_rs[i*REG_W +: REG_W]),
      .used       (src_used[i]),
      .sel        (fwd_sel[i*SEL_W +: SEL_W]),
      .load_hazard(hazard[i])
    );
  end

  always_comb begin
    new_entry.valid = issue_valid;
    new_entry.we    = issue_we;
    new_entry.rd    = HIST_RD_W'(issue_rd);
`ifdef HAZARD_LOAD_USE_STALL_EN
    new_entry.is_load = issue_is_load;
`else
    new_entry.is_load = 1'b0;
`endif
  end

`ifdef HAZARD_LOAD_USE_STALL_EN
  assign stall = |hazard;
`else
  assign stall = 1'b0;
  logic unused_load;
  assign unused_load = &{1'b0, issue_is_load, hazard};
`endif

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the history is control state and must be cleared on reset; a stale valid entry would forward garbage.
    if (!reset) begin
      hist <= '0;
    end else if (flush) begin
      hist <= '0;
    end else begin
      // NOTE: non-blocking assignments make every entry shift from its pre-edge neighbour, in any loop order.
      for (int k = FWD_DEPTH - 1; k >= 1; k--) begin
        hist[k] <= hist[k-1];
      end
      if (stall) begin
        hist[0] <= '0;
      end else begin
        hist[0] <= new_entry;
      end
    end
  end

`ifdef HAZARD_LOAD_USE_STALL_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (stall && !flush && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit at default parameters; expectations follow HAZARD_LOAD_USE_STALL_EN.
module tb_hazard_unit;

  localparam int REG_W = 5;
  localparam int SEL_W = 2;
`ifdef HAZARD_LOAD_USE_STALL_EN
  localparam bit LU = 1'b1;
`else
  localparam bit LU = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               issue_valid, issue_we, issue_is_load, flush;
  logic [REG_W-1:0]   issue_rd;
  logic [2*REG_W-1:0] src_rs;
  logic [1:0]         src_used;
  logic [2*SEL_W-1:0] fwd_sel;
  logic               stall;
  logic [15:0]        stall_count;

  hazard_unit dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
    .issue_is_load(issue_is_load), .src_rs(src_rs), .src_used(src_used),
    .flush(flush), .fwd_sel(fwd_sel), .stall(stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    bit    chk_sel;
    int    sel0;
    int    sel1;
    int    stl;
    int    cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [REG_W-1:0] rd,
                       input logic ld, input logic [REG_W-1:0] rs0,
                       input logic [REG_W-1:0] rs1, input logic [1:0] used,
                       input logic fl);
    issue_valid = v; issue_we = we; issue_rd = rd; issue_is_load = ld;
    src_rs = {rs1, rs0}; src_used = used; flush = fl;
  endtask

  task automatic expect_out(input string tag, input bit chk_sel, input int s0, input int s1,
                            input int stl, input int cnt);
    exp_t e;
    e.tag = tag; e.chk_sel = chk_sel; e.sel0 = s0; e.sel1 = s1; e.stl = stl; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    if (e.chk_sel) begin
      check({e.tag, ".sel0"}, int'(fwd_sel[SEL_W-1:0]), e.sel0);
      check({e.tag, ".sel1"}, int'(fwd_sel[2*SEL_W-1:SEL_W]), e.sel1);
    end
    check({e.tag, ".stall"}, int'(stall), e.stl);
    check({e.tag, ".count"}, int'(stall_count), e.cnt);
  endtask

  // Compare this cycle's outputs at the falling edge, then advance past the next rising edge.
  task automatic cycle();
    @(negedge clk);
    compare_out();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0);
    #2;
    expect_out("reset", 1'b1, 0, 0, 0, 0);
    compare_out();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    drive(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0);
    expect_out("issue_rd5", 1'b1, 0, 0, 0, 0);
    cycle();

    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd5, 2'b01, 1'b0);
    expect_out("alu_fwd_e0", 1'b1, 1, 0, 0, 0);
    cycle();

    drive(1'b1, 1'b1, 5'd7, 1'b0, 5'd5, 5'd0, 2'b01, 1'b0);
    expect_out("alu_fwd_e1", 1'b1, 2, 0, 0, 0);
    cycle();

    drive(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 5'd7, 2'b10, 1'b0);
    expect_out("first_rd7", 1'b1, 0, 1, 0, 0);
    cycle();

    drive(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 5'd7, 2'b10, 1'b0);
    expect_out("youngest_wins", 1'b1, 0, 1, 0, 0);
    cycle();

    drive(1'b1, 1'b0, 5'd9, 1'b0, 5'd0, 5'd0, 2'b11, 1'b0);
    expect_out("x0_no_match", 1'b1, 0, 0, 0, 0);
    cycle();

    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd0, 2'b01, 1'b0);
    expect_out("we0_no_match", 1'b1, 0, 0, 0, 0);
    cycle();

    drive(1'b1, 1'b1, 5'd3, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0);
    expect_out("issue_load3", 1'b1, 0, 0, 0, 0);
    cycle();

    drive(1'b1, 1'b1, 5'd4, 1'b0, 5'd3, 5'd0, 2'b01, 1'b0);
    expect_out("load_use", !LU, 1, 0, LU ? 1 : 0, 0);
    cycle();

    expect_out("load_fwd_e1", 1'b1, 2, 0, 0, LU ? 1 : 0);
    cycle();

    drive(1'b1, 1'b1, 5'd6, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0);
    expect_out("issue_load6", 1'b1, 0, 0, 0, LU ? 1 : 0);
    cycle();

    drive(1'b1, 1'b1, 5'd2, 1'b0, 5'd6, 5'd0, 2'b01, 1'b1);
    expect_out("flush_in_stall", !LU, 1, 0, LU ? 1 : 0, LU ? 1 : 0);
    cycle();

    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd6, 5'd4, 2'b11, 1'b0);
    expect_out("after_flush", 1'b1, 0, 0, 0, LU ? 1 : 0);
    cycle();

    drive(1'b1, 1'b1, 5'd8, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0);
    expect_out("issue_load8", 1'b1, 0, 0, 0, LU ? 1 : 0);
    cycle();

    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd8, 5'd8, 2'b11, 1'b0);
    expect_out("pre_async_reset", !LU, 1, 1, LU ? 1 : 0, LU ? 1 : 0);
    @(negedge clk);
    compare_out();
    #1;
    reset = 1'b0;
    #1;
    expect_out("async_reset", 1'b1, 0, 0, 0, 0);
    compare_out();
    @(posedge clk);
    #1;
    reset = 1'b1;

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
